// File: rtl/sort_mem_responder_pkg.sv
// Shared memory-message definitions for the 4-byte request/response streams.
// Holds the request/response structs, the type constants and a byte-count helper.
package sort_mem_responder_pkg;

  localparam logic [2:0] VC_MEM_REQ_READ   = 3'd0;
  localparam logic [2:0] VC_MEM_REQ_WRITE  = 3'd1;
  localparam logic [2:0] VC_MEM_RESP_READ  = 3'd0;
  localparam logic [2:0] VC_MEM_RESP_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // len==0 encodes a full 4-byte access
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/sort_mem_responder_if.sv
// Request/response stream bundle between the memory initiator and the responder.
interface sort_mem_responder_if import sort_mem_responder_pkg::*; ();

  mem_req_4B_t  mem_reqstream_msg;
  logic         mem_reqstream_val;
  logic         mem_reqstream_rdy;
  mem_resp_4B_t mem_respstream_msg;
  logic         mem_respstream_val;
  logic         mem_respstream_rdy;

  modport master (
    output mem_reqstream_msg, mem_reqstream_val, mem_respstream_rdy,
    input  mem_reqstream_rdy, mem_respstream_msg, mem_respstream_val
  );

  modport slave (
    input  mem_reqstream_msg, mem_reqstream_val, mem_respstream_rdy,
    output mem_reqstream_rdy, mem_respstream_msg, mem_respstream_val
  );

endinterface

// File: rtl/sort_mem_subword_lane.sv
// Byte-lane steering for subword accesses: right-justified read extract and
// write merge of an n-byte window starting at byte offset off. Bytes that
// would fall past lane 3 are dropped; trunc_o flags that case.
module sort_mem_subword_lane import sort_mem_responder_pkg::*; (
  input  logic [1:0]  off_i,
  input  logic [2:0]  n_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wword_o,
  output logic        trunc_o
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [2:0] src;
    logic [2:0] rel;
    logic       rd_hit;
    logic       wr_hit;

    // result byte k comes from lane off+k when inside the window and the word
    assign src    = {1'b0, off_i} + 3'(k);
    assign rd_hit = (3'(k) < n_i) && (src < 3'd4);
    assign rdata_o[8*k +: 8] = rd_hit ? word_i[{src[1:0], 3'b000} +: 8] : 8'h00;

    // lane k takes data byte k-off when k sits inside the written window
    assign rel    = 3'(k) - {1'b0, off_i};
    assign wr_hit = (3'(k) >= {1'b0, off_i}) && (rel < n_i);
    assign wword_o[8*k +: 8] = wr_hit ? wdata_i[{rel[1:0], 3'b000} +: 8] : word_i[8*k +: 8];
  end

  assign trunc_o = ({1'b0, off_i} + n_i) > 3'd4;

endmodule

// File: rtl/sort_mem_responder.sv
// Single-outstanding memory responder with programmable latency and subword
// access. The array is accessed at accept time; the response is held in a
// register until the consumer takes it.
// Optional: define SORT_MEM_RAND_STALL_EN to gate handshakes with an LFSR.
module sort_mem_responder import sort_mem_responder_pkg::*; #(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  sort_mem_responder_if.slave          mem,
  input  logic                         ext_wr_en,
  input  logic [$clog2(NUM_WORDS)-1:0] ext_addr,
  input  logic [31:0]                  ext_wdata,
  output logic [31:0]                  ext_rdata
);

  localparam int         AW     = $clog2(NUM_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  mem_resp_4B_t resp_q, resp_d;
  logic [31:0]  mem_q [NUM_WORDS];

  logic         req_stall, resp_stall;
  logic         accept;
  logic [AW-1:0] idx;
  logic [31:0]  rd_bytes, wr_word;
  logic         trunc;
  logic         unused_addr;

`ifdef SORT_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // free-running stall source, restarted from a fixed seed on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign req_stall  = lfsr_q[0];
  assign resp_stall = lfsr_q[1];
`else
  assign req_stall  = 1'b0;
  assign resp_stall = 1'b0;
`endif

  // reset gates rdy directly so it reads 0 for the whole assertion
  assign mem.mem_reqstream_rdy  = reset && (state_q == IDLE) && !req_stall;
  assign mem.mem_respstream_val = (state_q == RESP) && !resp_stall;
  assign mem.mem_respstream_msg = resp_q;

  assign accept      = mem.mem_reqstream_val && mem.mem_reqstream_rdy;
  assign idx         = mem.mem_reqstream_msg.addr[2 +: AW];
  assign unused_addr = ^{mem.mem_reqstream_msg.addr[31:2+AW]};
  assign ext_rdata   = mem_q[ext_addr];

  sort_mem_subword_lane u_lane (
    .off_i   (mem.mem_reqstream_msg.addr[1:0]),
    .n_i     (byte_count(mem.mem_reqstream_msg.len)),
    .word_i  (mem_q[idx]),
    .wdata_i (mem.mem_reqstream_msg.data),
    .rdata_o (rd_bytes),
    .wword_o (wr_word),
    .trunc_o (trunc)
  );

  // array: preload port first so a same-cycle request write takes precedence
  always_ff @(posedge clk) begin
    if (ext_wr_en) mem_q[ext_addr] <= ext_wdata;
    if (accept && mem.mem_reqstream_msg.type_ == VC_MEM_REQ_WRITE) mem_q[idx] <= wr_word;
  end

  // state, latency counter and held response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // next-state: capture response at accept, count down latency, wait for consumer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_d.type_  = mem.mem_reqstream_msg.type_;
          resp_d.opaque = mem.mem_reqstream_msg.opaque;
          resp_d.len    = mem.mem_reqstream_msg.len;
          resp_d.test   = trunc ? 2'b01 : 2'b00;
          resp_d.data   = (mem.mem_reqstream_msg.type_ == VC_MEM_REQ_READ) ? rd_bytes : 32'h0;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = DELAY;
            cnt_d   = LAT_M1;
          end
        end
      end
      DELAY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (mem.mem_respstream_val && mem.mem_respstream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sort_mem_responder.sv
// Directed bench: driver pushes hand-computed expected responses into a
// queue; an independent monitor pops and compares on each response handshake.
module tb_sort_mem_responder;
  import sort_mem_responder_pkg::*;

  localparam int LAT = 3;
  localparam int NW  = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_wr_en = 1'b0;
  logic [7:0]  ext_addr = 8'd0;
  logic [31:0] ext_wdata = 32'h0;
  logic [31:0] ext_rdata;

  sort_mem_responder_if mif ();

  sort_mem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (mif),
    .ext_wr_en (ext_wr_en),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit lat_pend = 1'b0;
  logic [7:0] op_ctr = 8'h10;
  mem_resp_4B_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: latency of first val, then scoreboard compare on handshake
  always @(negedge clk) begin
    mem_resp_4B_t e;
    if (reset && mif.mem_respstream_val) begin
      if (lat_pend) begin
        lat_pend = 1'b0;
`ifndef SORT_MEM_RAND_STALL_EN
        chk("latency", 64'(cyc - acc_cyc), 64'(LAT + 1));
`endif
      end
      if (mif.mem_respstream_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_msg", 64'(mif.mem_respstream_msg), 64'(e));
        end
      end
    end
  end

  task automatic do_req(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] d, input logic [31:0] ed, input logic [1:0] et,
                        input bit want, input bit wt);
    int n;
    mem_resp_4B_t e;
    @(negedge clk);
    op_ctr++;
    mif.mem_reqstream_msg = '{type_: t, opaque: op_ctr, addr: a, len: l, data: d};
    mif.mem_reqstream_val = 1'b1;
    n = 0;
    while (!mif.mem_reqstream_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_timeout", 64'(n), 64'd0);
    if (want) begin
      e = '{type_: t, opaque: op_ctr, test: et, len: l, data: ed};
      exp_q.push_back(e);
      acc_cyc  = cyc;
      lat_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    mif.mem_reqstream_val = 1'b0;
    ext_wr_en = 1'b0;
    if (want && wt) begin
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) chk("resp_timeout", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic peek(input string name, input logic [7:0] w, input logic [31:0] exp);
    ext_wr_en = 1'b0;
    ext_addr = w;
    #1;
    chk(name, 64'(ext_rdata), 64'(exp));
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] l, input logic [31:0] ed, input logic [1:0] et);
    do_req(VC_MEM_REQ_READ, a, l, 32'h0, ed, et, 1'b1, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d, input logic [1:0] et);
    do_req(VC_MEM_REQ_WRITE, a, l, d, 32'h0, et, 1'b1, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    mem_resp_4B_t snap;
    logic [31:0] m [4];
    logic [31:0] t0;
    mif.mem_reqstream_msg  = '0;
    mif.mem_reqstream_val  = 1'b0;
    mif.mem_respstream_rdy = 1'b1;

    // reset state
    #1 reset = 1'b0;
    #2;
    chk("rst_req_rdy", 64'(mif.mem_reqstream_rdy), 64'd0);
    chk("rst_resp_val", 64'(mif.mem_respstream_val), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(mif.mem_reqstream_rdy), 64'd1);

    // full-word write/read, address wrap
    wr(32'h0000_0008, 2'd0, 32'hDEADBEEF, 2'b00);
    rd(32'h0000_0008, 2'd0, 32'hDEADBEEF, 2'b00);
    rd(32'h0000_0408, 2'd0, 32'hDEADBEEF, 2'b00);

    // preload and subword accesses
    @(negedge clk);
    ext_wr_en = 1'b1; ext_addr = 8'd3; ext_wdata = 32'h11223344;
    @(negedge clk);
    ext_wr_en = 1'b0;
    peek("preload_w3", 8'd3, 32'h11223344);
    rd(32'h0000_000D, 2'd2, 32'h0000_2233, 2'b00);
    wr(32'h0000_000E, 2'd3, 32'h00AABBCC, 2'b01);
    peek("merge_w3", 8'd3, 32'hBBCC3344);
    rd(32'h0000_000F, 2'd2, 32'h0000_00BB, 2'b01);
    rd(32'h0000_000C, 2'd1, 32'h0000_0044, 2'b00);
    rd(32'h0000_000C, 2'd0, 32'hBBCC3344, 2'b00);

    // unknown type: response with zero data, array untouched
    do_req(3'd2, 32'h0000_000C, 2'd0, 32'hFFFFFFFF, 32'h0, 2'b00, 1'b1, 1'b1);
    peek("other_type_w3", 8'd3, 32'hBBCC3344);

    // preload and request write to same word on the accept edge
    ext_wr_en = 1'b1; ext_addr = 8'd5; ext_wdata = 32'h99999999;
    wr(32'h0000_0014, 2'd0, 32'h55555555, 2'b00);
    peek("collision_w5", 8'd5, 32'h55555555);

    // consumer backpressure: message held stable
    mif.mem_respstream_rdy = 1'b0;
    do_req(VC_MEM_REQ_READ, 32'h0000_0014, 2'd0, 32'h0, 32'h55555555, 2'b00, 1'b1, 1'b0);
    n = 0;
    while (!mif.mem_respstream_val && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("stall_val_timeout", 64'(n), 64'd0);
    snap = mif.mem_respstream_msg;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_val", 64'(mif.mem_respstream_val), 64'd1);
      chk("stall_msg", 64'(mif.mem_respstream_msg), 64'(snap));
      chk("stall_req_rdy", 64'(mif.mem_reqstream_rdy), 64'd0);
    end
    @(posedge clk);
    #1 mif.mem_respstream_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_handshake", 64'(mif.mem_reqstream_rdy), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // reset while in DELAY: response dropped, write kept
    do_req(VC_MEM_REQ_WRITE, 32'h0000_0050, 2'd0, 32'hCAFE0001, 32'h0, 2'b00, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_req_rdy", 64'(mif.mem_reqstream_rdy), 64'd0);
    chk("midrst_resp_val", 64'(mif.mem_respstream_val), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_rdy_after", 64'(mif.mem_reqstream_rdy), 64'd1);
    repeat (LAT + 4) @(negedge clk);
    peek("midrst_write_kept", 8'd20, 32'hCAFE0001);

    // bubble sort of [5,3,1,4] at words 32..35 through the request port
    m[0] = 32'd5; m[1] = 32'd3; m[2] = 32'd1; m[3] = 32'd4;
    for (int i = 0; i < 4; i++) wr(32'h80 + 32'(4*i), 2'd0, m[i], 2'b00);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3 - i; j++) begin
        rd(32'h80 + 32'(4*j), 2'd0, m[j], 2'b00);
        rd(32'h80 + 32'(4*(j+1)), 2'd0, m[j+1], 2'b00);
        if (m[j] > m[j+1]) begin
          t0 = m[j]; m[j] = m[j+1]; m[j+1] = t0;
          wr(32'h80 + 32'(4*j), 2'd0, m[j], 2'b00);
          wr(32'h80 + 32'(4*(j+1)), 2'd0, m[j+1], 2'b00);
        end
      end
    end
    peek("sort_0", 8'd32, 32'd1);
    peek("sort_1", 8'd33, 32'd3);
    peek("sort_2", 8'd34, 32'd4);
    peek("sort_3", 8'd35, 32'd5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_mem_responder.md
Name: sort_mem_responder

Overview:
- Memory-side responder for the 4B memory request/response interface driven by the sort accelerator's memory initiator port.
- Services one request at a time against an internal word array.
- Latency is programmable; subword (byte/halfword/3-byte) reads and writes are supported.
- Used as the memory model in accelerator unit/integration benches and as a small scratchpad behind the accelerator.

Parameters:
- NUM_WORDS, 256, number of 32-bit words in the array (power of two).
- LATENCY, 1, cycles between request accept and response valid, beyond the minimum of one; range 0..15.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset; asynchronous, active-low (asserted at 0)
- mem_reqstream_msg  input  $bits(mem_req_4B_t)  request: type_, opaque, addr, len, data
- mem_reqstream_val  input  1  request valid
- mem_reqstream_rdy  output  1  responder can accept a request
- mem_respstream_msg  output  $bits(mem_resp_4B_t)  response: type_, opaque, test, len, data
- mem_respstream_val  output  1  response valid
- mem_respstream_rdy  input  1  consumer accepts the response
- ext_wr_en  input  1  bench preload write strobe
- ext_addr  input  $clog2(NUM_WORDS)  preload/peek word index
- ext_wdata  input  32  preload data
- ext_rdata  output  32  combinational read of the word at ext_addr

Behaviour:
- States: IDLE, DELAY, RESP.
- Reset (reset==0, async): state goes to IDLE; delay counter 0; response register 0. mem_reqstream_rdy=0 and mem_respstream_val=0 while reset is asserted. Array contents are not cleared.
- IDLE:
  - rdy=1.
  - On val&&rdy the request is accepted and the array is accessed that same edge: write commits, read data is captured.
  - Next state: RESP if LATENCY==0, else DELAY with counter=LATENCY-1.
- DELAY: rdy=0; counter decrements each cycle; at counter==0 go to RESP.
- RESP:
  - rdy=0, resp val=1, message held stable until rdy.
  - On val&&rdy go to IDLE.
  - No bypass: minimum throughput is one request per LATENCY+2 cycles.
- Word index: addr[2+$clog2(NUM_WORDS)-1:2]; higher address bits are ignored, so out-of-range addresses wrap.
- Byte offset: off=addr[1:0]. Byte count n = 4 when len==0, else n = len.
- READ:
  - Bytes off..off+n-1 of the word are returned right-justified and zero-extended.
  - Lanes past byte 3 are not read; their result bytes are 0.
- WRITE:
  - The low n bytes of data are written to lanes off..off+n-1; lanes past byte 3 are dropped.
  - Response data=0.
- Any other type_: no array effect; a response is still sent with data=0.
- Response fields:
  - type_ equals request type_; opaque echoed; len echoed; test=0.
  - test=2'b01 if off+n>4 (misaligned truncation).
- ext_wr_en writes the full word in any state. If it hits the same word as an accepted request write in the same cycle, the request write wins.
- Reset mid-DELAY or mid-RESP: the pending response is discarded and never presented. A write committed at accept remains in the array.

Optional Feature:
- SORT_MEM_RAND_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset, advanced every cycle) gates handshakes.
  - In IDLE, rdy=0 when lfsr[0]==1.
  - In RESP, val=0 when lfsr[1]==1.
  - The held message is unchanged while val is gated.
- Not defined: no stalls; behaviour exactly as above.

Decomposition:
- Shared package (mem-msgs include): existing mem_req_4B_t, mem_resp_4B_t, and the VC_MEM_REQ/RESP type constants. No new typedefs.
- Local state_t enum stays in this module.
- One natural sub-module, sort_mem_subword_lane: combinational byte-lane extract for reads and merge for writes, from off, n and the word.

Test Plan:
- Write addr=0x0000_0008, len=0, data=0xDEADBEEF, then read the same address with len=0. Expected: read resp data=0xDEADBEEF; write resp data=0; opaque echoed; resp val appears exactly LATENCY+1 cycles after accept.
- Preload word 3 with 0x11223344 via ext, then read addr=0x0000_000D, len=2. Expected: data=0x00002233, test=0.
- Write addr=0x0000_000E, len=3, data=0x00AABBCC over 0x11223344. Expected: word becomes 0xBBCC3344, test=2'b01.
- Hold mem_respstream_rdy=0 for 5 cycles. Expected: val and msg stable throughout; rdy=0 until the response fires; next request accepted the cycle after the response handshake.
- Assert reset during DELAY. Expected: no response ever emitted; rdy=1 the first cycle after reset deasserts; the earlier write is visible on ext_rdata.
- Bubble sort of [5,3,1,4] driven by the accelerator with LATENCY=3. Expected: ext peek gives [1,3,4,5]; repeat with SORT_MEM_RAND_STALL_EN defined, same result.
